// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: runs one post-IP 64-bit block through
// ROUNDS Feistel rounds, one round per clock. It shares an external
// f-function and fetches subkeys from an external key-schedule store by index.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   InValid/InReady     input handshake for DataIn/Decrypt
//   DataIn   [63:0]     post-IP block {L0, R0}
//   Decrypt             0 = subkeys ascending, 1 = descending (sampled at accept)
//   SubKeyIndex         subkey index requested this cycle
//   SubKey   [47:0]     subkey for SubKeyIndex (same cycle)
//   FRight   [31:0]     right half to the f-function
//   FKey     [47:0]     subkey to the f-function
//   FOut     [31:0]     f-function result (same cycle)
//   OutValid/OutReady   output handshake for DataOut
//   DataOut  [63:0]     pre-FP result {R16, L16}
//   Busy                high while a block is in flight (ROUND or DONE)
//   RoundCount          current round number, debug
module des_round_sequencer #(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [63:0]      DataIn,
  input  logic             Decrypt,
  output logic [CNT_W-1:0] SubKeyIndex,
  input  logic [47:0]      SubKey,
  output logic [31:0]      FRight,
  output logic [47:0]      FKey,
  input  logic [31:0]      FOut,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [63:0]      DataOut,
  output logic             Busy,
  output logic [CNT_W-1:0] RoundCount
);

  localparam int unsigned HALF_W = 32;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [HALF_W-1:0] l_half;
  logic [HALF_W-1:0] r_half;
  logic [CNT_W-1:0]  rnd;
  logic              mode;

  logic accept;
  logic last_rnd;

  assign accept   = InValid && (state == S_IDLE);
  assign last_rnd = (rnd == LAST_RND);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)   state_nxt = S_ROUND;
      S_ROUND: if (last_rnd) state_nxt = S_DONE;
      S_DONE:  if (OutReady) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Feistel datapath: halves, round counter and direction latched at accept
  always_ff @(posedge Clk) begin
    if (Reset) begin
      l_half <= '0;
      r_half <= '0;
      rnd    <= '0;
      mode   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            l_half <= DataIn[63:32];
            r_half <= DataIn[31:0];
            mode   <= Decrypt;
            rnd    <= '0;
          end
        end
        S_ROUND: begin
          l_half <= r_half;
          r_half <= l_half ^ FOut;
          rnd    <= last_rnd ? '0 : rnd + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; f-function inputs stay deterministic outside ROUND
  always_comb begin
    InReady     = 1'b0;
    OutValid    = 1'b0;
    Busy        = 1'b0;
    DataOut     = '0;
    SubKeyIndex = '0;
    FRight      = r_half;
    FKey        = SubKey;
    case (state)
      S_IDLE: begin
        InReady = 1'b1;
      end
      S_ROUND: begin
        Busy        = 1'b1;
        SubKeyIndex = mode ? (LAST_RND - rnd) : rnd;
      end
      S_DONE: begin
        Busy     = 1'b1;
        OutValid = 1'b1;
        // Last round's swap is undone here: present {R, L}
        DataOut  = {r_half, l_half};
      end
      default: begin
      end
    endcase
  end

  assign RoundCount = rnd;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Testbench for des_round_sequencer: provides the f-function and key-schedule
// store, keeps a full DES reference, and scoreboards DataOut at each handshake.
module tb_des_round_sequencer;

  localparam int unsigned ROUNDS = 16;
  localparam int unsigned CNT_W  = 4;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                              12,13,14,15,16,17, 16,17,18,19,20,21,
                              20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic             Clk;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [63:0]      DataIn;
  logic             Decrypt;
  logic [CNT_W-1:0] SubKeyIndex;
  logic [47:0]      SubKey;
  logic [31:0]      FRight;
  logic [47:0]      FKey;
  logic [31:0]      FOut;
  logic             OutValid;
  logic             OutReady;
  logic [63:0]      DataOut;
  logic             Busy;
  logic [CNT_W-1:0] RoundCount;

  int          f_mode;        // 0: f=0, 1: f=all ones, 2: real DES f
  logic [47:0] ks_cur [16];
  logic [63:0] exp_q [$];
  logic [CNT_W-1:0] idx_log [$];
  int n_checks = 0;
  int n_fail   = 0;

  des_round_sequencer #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .DataIn(DataIn), .Decrypt(Decrypt), .SubKeyIndex(SubKeyIndex),
    .SubKey(SubKey), .FRight(FRight), .FKey(FKey), .FOut(FOut),
    .OutValid(OutValid), .OutReady(OutReady), .DataOut(DataOut),
    .Busy(Busy), .RoundCount(RoundCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // DES reference primitives (bit 1 = MSB, as in the standard tables)
  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_f(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_f(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  c;
    int row;
    int col;
    x = e_f(r) ^ k;
    for (int b = 0; b < 8; b++) begin
      c   = x[47-6*b -: 6];
      row = 2 * int'(c[5]) + int'(c[0]);
      col = int'(c[4:1]);
      s[31-4*b -: 4] = 4'(SBOX[b*64 + row*16 + col]);
    end
    return p_f(s);
  endfunction

  task automatic make_ks(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    cd = pc1_f(key);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < SHIFTS[i]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks_cur[i] = pc2_f({c, d});
    end
  endtask

  // Whole-block DES using the current key schedule
  function automatic logic [63:0] des_ref(input logic [63:0] blk, input bit dec);
    logic [63:0] x;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    x = ip_f(blk);
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ des_f(r, dec ? ks_cur[15-i] : ks_cur[i]);
      l = t;
    end
    return fp_f({r, l});
  endfunction

  assign SubKey = ks_cur[SubKeyIndex];
  assign FOut   = (f_mode == 0) ? 32'h0 :
                  (f_mode == 1) ? 32'hFFFF_FFFF : des_f(FRight, FKey);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: log subkey indices in ROUND, pop scoreboard at each output handshake
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Busy && !OutValid) idx_log.push_back(SubKeyIndex);
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h with empty scoreboard at %0t", DataOut, $time);
        end else begin
          chk("dataout", DataOut, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [63:0] din, input bit dec, input logic [63:0] exp,
                      input bit expect_out);
    int t;
    t = 0;
    while (!InReady && t < 100) begin
      @(posedge Clk); #1;
      t++;
    end
    if (t >= 100) chk("inready_timeout", 64'(t), 64'(0));
    if (expect_out) exp_q.push_back(exp);
    DataIn  = din;
    Decrypt = dec;
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    DataIn  = {$urandom(), $urandom()};
    Decrypt = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input bit rnd_bp);
    int t;
    t = 0;
    while (Busy && t < 400) begin
      if (rnd_bp) OutReady = 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
      t++;
    end
    OutReady = 1'b1;
    if (t >= 400) chk("done_timeout", 64'(t), 64'(0));
  endtask

  task automatic check_idx(input bit dec);
    chk("subkey_index_count", 64'(idx_log.size()), 64'(ROUNDS));
    for (int i = 0; i < idx_log.size() && i < 16; i++)
      chk($sformatf("subkey_index[%0d]", i), 64'(idx_log[i]), 64'(dec ? 15 - i : i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pt;
    logic [63:0] key;
    logic [63:0] exp;
    bit          dec;
    int          t;
    int          lat;

    Reset = 1'b1; InValid = 1'b0; DataIn = '0; Decrypt = 1'b0; OutReady = 1'b1;
    f_mode = 0;
    make_ks(64'h0);
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_inready",  64'(InReady),     64'(1));
    chk("reset_outvalid", 64'(OutValid),    64'(0));
    chk("reset_busy",     64'(Busy),        64'(0));
    chk("reset_dataout",  DataOut,          64'h0);
    chk("reset_skidx",    64'(SubKeyIndex), 64'(0));
    chk("reset_fright",   64'(FRight),      64'(0));
    chk("reset_rndcnt",   64'(RoundCount),  64'(0));
    Reset = 1'b0;
    @(posedge Clk); #1;

    // f = 0: halves just swap each round; even round count restores them, then {R,L}
    f_mode = 0;
    idx_log.delete();
    send(64'h0123456789ABCDEF, 1'b0, 64'h89ABCDEF01234567, 1'b1);
    lat = 0;
    while (!OutValid && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(ROUNDS));
    wait_done(1'b0);
    check_idx(1'b0);

    // f = all ones on zero input: 4-round period returns to zero
    f_mode = 1;
    send(64'h0, 1'($urandom_range(0, 1)), 64'h0, 1'b1);
    wait_done(1'b0);

    // Known-answer DES encrypt and decrypt
    f_mode = 2;
    make_ks(64'h133457799BBCDFF1);
    idx_log.delete();
    send(ip_f(64'h0123456789ABCDEF), 1'b0, ip_f(64'h85E813540F0AB405), 1'b1);
    wait_done(1'b0);
    check_idx(1'b0);
    idx_log.delete();
    send(ip_f(64'h85E813540F0AB405), 1'b1, ip_f(64'h0123456789ABCDEF), 1'b1);
    wait_done(1'b0);
    check_idx(1'b1);

    // Reset in the middle of round 7 abandons the block
    send({$urandom(), $urandom()}, 1'b0, 64'h0, 1'b0);
    t = 0;
    while (RoundCount != CNT_W'(7) && t < 40) begin
      @(posedge Clk); #1;
      t++;
    end
    chk("reach_round7", 64'(RoundCount), 64'(7));
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("midreset_inready",  64'(InReady),    64'(1));
    chk("midreset_outvalid", 64'(OutValid),   64'(0));
    chk("midreset_busy",     64'(Busy),       64'(0));
    chk("midreset_rndcnt",   64'(RoundCount), 64'(0));
    pt = {$urandom(), $urandom()};
    send(ip_f(pt), 1'b0, ip_f(des_ref(pt, 1'b0)), 1'b1);
    wait_done(1'b0);

    // Backpressure in DONE with stray InValid during ROUND and DONE
    pt  = {$urandom(), $urandom()};
    exp = ip_f(des_ref(pt, 1'b1));
    OutReady = 1'b0;
    send(ip_f(pt), 1'b1, exp, 1'b1);
    repeat (3) @(posedge Clk);
    #1;
    InValid = 1'b1; DataIn = {$urandom(), $urandom()}; Decrypt = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    InValid = 1'b0;
    t = 0;
    while (!OutValid && t < 40) begin
      @(posedge Clk); #1;
      t++;
    end
    InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_outvalid", 64'(OutValid), 64'(1));
      chk("bp_dataout",  DataOut,       exp);
      chk("bp_inready",  64'(InReady),  64'(0));
      @(posedge Clk); #1;
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    @(posedge Clk); #1;
    chk("bp_release_inready",  64'(InReady),  64'(1));
    chk("bp_release_outvalid", 64'(OutValid), 64'(0));
    repeat (3) @(posedge Clk);
    #1;
    chk("bp_no_stray_block", 64'(Busy), 64'(0));

    // Randomized blocks with random keys, directions and backpressure
    for (int n = 0; n < 10; n++) begin
      key = {$urandom(), $urandom()};
      pt  = {$urandom(), $urandom()};
      dec = 1'($urandom_range(0, 1));
      if (n % 4 == 3) begin
        f_mode = 0;
        send(pt, dec, {pt[31:0], pt[63:32]}, 1'b1);
      end else begin
        f_mode = 2;
        make_ks(key);
        send(ip_f(pt), dec, ip_f(des_ref(pt, dec)), 1'b1);
      end
      wait_done(1'b1);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_round_sequencer.md
Name: des_round_sequencer

Overview:
- Iterative DES round controller. Runs one 64-bit block through 16 Feistel rounds, one round per clock.
- Shares a single external f-function instance (32-bit right half, 48-bit subkey in; 32-bit result out) across all rounds.
- Requests the per-round subkey from an external key-schedule store by index.
- Sits between the initial permutation (IP) stage and the final permutation (FP) stage. IP and FP are outside this block.

Parameters:
- ROUNDS, 16, number of Feistel rounds per block; must be even, ≥2.
- CNT_W, 4, round counter width; 2**CNT_W ≥ ROUNDS.

Ports:
- Clk  input  1  single clock, all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  DataIn/Decrypt valid.
- InReady  output  1  block can accept a new input.
- DataIn  input  64  post-IP block; [63:32]=L0, [31:0]=R0.
- Decrypt  input  1  0=encrypt (subkeys 0..15), 1=decrypt (15..0); sampled at accept.
- SubKeyIndex  output  CNT_W  subkey index requested this cycle.
- SubKey  input  48  subkey for SubKeyIndex, combinational same cycle.
- FRight  output  32  right half to the f-function.
- FKey  output  48  subkey to the f-function (SubKey passed through).
- FOut  input  32  f-function result, combinational same cycle.
- OutValid  output  1  DataOut valid.
- OutReady  input  1  downstream accepts DataOut.
- DataOut  output  64  pre-FP result {R16, L16}.
- Busy  output  1  high in ROUND or DONE.
- RoundCount  output  CNT_W  current round number, for debug.

Behaviour:
- Reset (synchronous, dominates all other inputs, including mid-round): state=IDLE, L=R=0, RoundCount=0, mode=0. Outputs after reset: InReady=1, OutValid=0, Busy=0, DataOut=0, SubKeyIndex=0, FRight=0.
- States: IDLE, ROUND, DONE.
- IDLE:
  - InReady=1.
  - On InValid&InReady: L<=DataIn[63:32], R<=DataIn[31:0], mode<=Decrypt, RoundCount<=0, go to ROUND.
  - Otherwise hold.
- ROUND:
  - InReady=0.
  - Combinational outputs each cycle: FRight=R; SubKeyIndex = mode ? (ROUNDS-1-RoundCount) : RoundCount; FKey=SubKey.
  - At each clock edge: L<=R, R<=L^FOut, RoundCount<=RoundCount+1.
  - When RoundCount==ROUNDS-1, this edge performs the last round: RoundCount<=0, go to DONE.
  - Exactly ROUNDS cycles are spent in ROUND.
- DONE:
  - OutValid=1; DataOut={R,L} (final swap undone); held stable until accepted.
  - On OutReady: go to IDLE at the next edge.
  - InValid is ignored in DONE (InReady=0). No same-cycle accept.
- FRight, FKey and SubKeyIndex outside ROUND: FRight=R, FKey=SubKey, SubKeyIndex=0. Their values outside ROUND are don't-care to consumers but must be deterministic.
- Latency: accept edge → OutValid asserted 16 cycles later with OutReady held high. Minimum issue interval is 18 cycles (1 IDLE + 16 ROUND + 1 DONE).
- InValid, DataIn and Decrypt changes during ROUND/DONE have no effect.
- Backpressure: OutReady low holds DONE indefinitely. DataOut and internal state do not change.
- XOR is bitwise 32-bit; no arithmetic widths grow; RoundCount wraps only through the explicit reset to 0.

Test Plan:
- Reset mid-ROUND (assert Reset at round 7) → next cycle state IDLE, InReady=1, OutValid=0, Busy=0, RoundCount=0. A new block accepted afterwards completes normally.
- Bench f model returns FOut=0; DataIn=0x0123456789ABCDEF, encrypt → after 16 round cycles DataOut=0x89ABCDEF01234567, OutValid=1.
- Bench f model returns FOut=0xFFFFFFFF; DataIn=0x0000000000000000 → DataOut=0x0000000000000000. Checks the 4-round XOR period across 16 rounds.
- Full DES with bench IP/FP, reference f-function and key schedule; key 0x133457799BBCDFF1, plaintext 0x0123456789ABCDEF, encrypt → ciphertext 0x85E813540F0AB405.
- Same key with Decrypt=1 on 0x85E813540F0AB405 → 0x0123456789ABCDEF. SubKeyIndex sequence observed is 15,14,…,0.
- Backpressure: OutReady=0 for 5 cycles in DONE → OutValid and DataOut stable, InReady=0. OutReady=1 → IDLE next cycle, InReady=1. A second InValid pulsed during ROUND is ignored.
